h14tx_pll_ctrl: RTL and testbench

- Sequencing controller on the control side of the HDMI 1.4 transmit PLL.
- Drives the PLL's active-low reset and watches the PLL's asynchronous `lock` output.
- Qualifies lock as stable before releasing the transmit datapath reset, and re-runs the PLL on loss of lock.
- Escalates to a latched fault after repeated lock timeouts.
- Runs entirely on the 70 MHz reference clock.

---
 rtl/h14tx_pkg.sv | 25 ++
 rtl/h14tx_sync.sv | 27 ++
 rtl/h14tx_pll_ctrl.sv | 146 ++++++++++++++
 tb/tb_h14tx_pll_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/h14tx_pkg.sv
// Shared types and default timing for the HDMI 1.4 transmit PLL control path.
// Cycle constants are derived from the 70 MHz reference clock.
package h14tx_pkg;

    typedef enum logic [2:0] {
        RESET     = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } pll_ctrl_state_e;

    localparam int REF_CLK_HZ              = 70_000_000;
    localparam int DEF_RESET_CYCLES        = REF_CLK_HZ / 1_000_000;  // 1 us
    localparam int DEF_LOCK_TIMEOUT_CYCLES = REF_CLK_HZ / 1_000;      // 1 ms
    localparam int DEF_LOCK_STABLE_CYCLES  = REF_CLK_HZ / 10_000;     // 100 us
    localparam int DEF_MAX_RETRIES         = 3;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/h14tx_sync.sv
// Generic 2-flop synchronizer with synchronous reset to 0.
// Used for any single-bit or multi-bit independent control signal crossing into the local clock.
module h14tx_sync #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/h14tx_pll_ctrl.sv
// HDMI 1.4 TX PLL sequencer: pulses the PLL reset, qualifies lock, releases the
// datapath reset, re-runs on lock loss and latches a fault after repeated timeouts.
module h14tx_pll_ctrl
    import h14tx_pkg::*;
#(
    parameter int ResetCycles       = DEF_RESET_CYCLES,
    parameter int LockTimeoutCycles = DEF_LOCK_TIMEOUT_CYCLES,
    parameter int LockStableCycles  = DEF_LOCK_STABLE_CYCLES,
    parameter int MaxRetries        = DEF_MAX_RETRIES
) (
    input  logic       ref_clk_70mhz,
    input  logic       rst,
    input  logic       lock,
    input  logic       restart,
    output logic       pll_rst_n,
    output logic       tx_rst,
    output logic       ready,
    output logic       fault,
    output logic [3:0] retry_count,
    output logic [7:0] loss_count
);

    localparam int CntW = $clog2(max3(ResetCycles, LockTimeoutCycles, LockStableCycles)) + 1;
    localparam logic [CntW-1:0] RstLoad     = CntW'(ResetCycles);
    localparam logic [CntW-1:0] TimeoutLoad = CntW'(LockTimeoutCycles);
    localparam logic [CntW-1:0] StableLoad  = CntW'(LockStableCycles);

    logic lock_s;

    h14tx_sync #(.W(1)) u_lock_sync (
        .clk (ref_clk_70mhz),
        .rst (rst),
        .d   (lock),
        .q   (lock_s)
    );

    pll_ctrl_state_e state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [3:0]      retry_q, retry_d;
    logic [7:0]      loss_q, loss_d;
    logic            pll_rst_n_q, pll_rst_n_d;
    logic            tx_rst_q, tx_rst_d;
    logic            ready_q, ready_d;
    logic            fault_q, fault_d;
    logic            cnt_done;

    // cnt counts edges left in the current state; the state exits on the edge that takes it to 0.
    assign cnt_done = (cnt_q <= CntW'(1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_done ? '0 : cnt_q - CntW'(1);
        retry_d = retry_q;
        loss_d  = loss_q;

        case (state_q)
            RESET: begin
                if (cnt_done) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = TimeoutLoad;
                end
            end
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = STABLE;
                    cnt_d   = StableLoad;
                end else if (cnt_done) begin
                    retry_d = retry_q + 4'd1;
                    if (retry_d == 4'(MaxRetries)) begin
                        state_d = FAULT;
                        cnt_d   = '0;
                    end else begin
                        state_d = RESET;
                        cnt_d   = RstLoad;
                    end
                end
            end
            STABLE: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = TimeoutLoad;
                end else if (cnt_done) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    retry_d = '0;
                end
            end
            RUN: begin
                if (!lock_s) begin
                    state_d = RESET;
                    cnt_d   = RstLoad;
                    if (loss_q != 8'hFF) begin
                        loss_d = loss_q + 8'd1;
                    end
                end
            end
            FAULT: begin
                if (restart) begin
                    state_d = RESET;
                    cnt_d   = RstLoad;
                    retry_d = '0;
                end
            end
            default: begin
                state_d = RESET;
                cnt_d   = RstLoad;
            end
        endcase

        // Outputs are decoded from the next state so they change on the transition edge.
        pll_rst_n_d = (state_d == WAIT_LOCK) || (state_d == STABLE) || (state_d == RUN);
        ready_d     = (state_d == RUN);
        tx_rst_d    = !ready_d;
        fault_d     = (state_d == FAULT);
    end

    always_ff @(posedge ref_clk_70mhz) begin
        if (rst) begin
            state_q     <= RESET;
            cnt_q       <= RstLoad;
            retry_q     <= '0;
            loss_q      <= '0;
            pll_rst_n_q <= 1'b0;
            tx_rst_q    <= 1'b1;
            ready_q     <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            loss_q      <= loss_d;
            pll_rst_n_q <= pll_rst_n_d;
            tx_rst_q    <= tx_rst_d;
            ready_q     <= ready_d;
            fault_q     <= fault_d;
        end
    end

    assign pll_rst_n   = pll_rst_n_q;
    assign tx_rst      = tx_rst_q;
    assign ready       = ready_q;
    assign fault       = fault_q;
    assign retry_count = retry_q;
    assign loss_count  = loss_q;

endmodule

// File: tb/tb_h14tx_pll_ctrl.sv
// Bench for h14tx_pll_ctrl: directed lock/restart/reset scenarios, a phase/elapsed-time
// model of the sequencer checked every cycle, and hand-computed edge-exact expectations.
module tb_h14tx_pll_ctrl;

    localparam int RC = 4;
    localparam int TO = 20;
    localparam int SC = 8;
    localparam int MR = 2;

    localparam int P_RST  = 0;
    localparam int P_WAIT = 1;
    localparam int P_STB  = 2;
    localparam int P_RUN  = 3;
    localparam int P_FLT  = 4;

    logic       clk;
    logic       rst;
    logic       lock;
    logic       restart;
    logic       pll_rst_n;
    logic       tx_rst;
    logic       ready;
    logic       fault;
    logic [3:0] retry_count;
    logic [7:0] loss_count;

    int checks   = 0;
    int failures = 0;

    h14tx_pll_ctrl #(
        .ResetCycles       (RC),
        .LockTimeoutCycles (TO),
        .LockStableCycles  (SC),
        .MaxRetries        (MR)
    ) dut (
        .ref_clk_70mhz (clk),
        .rst           (rst),
        .lock          (lock),
        .restart       (restart),
        .pll_rst_n     (pll_rst_n),
        .tx_rst        (tx_rst),
        .ready         (ready),
        .fault         (fault),
        .retry_count   (retry_count),
        .loss_count    (loss_count)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 40) begin
                $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
            end
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (ready !== 1'b1 && n < 60) begin
            step(1);
            n++;
        end
        chk(name, 32'(ready), 32'd1);
    endtask

    // ---------------- behavioural model ----------------
    // Tracks the sequencer as a phase plus edges elapsed in it; lock seen by the
    // sequencer is the pin value from two edges earlier.
    int m_ph      = P_RST;
    int m_el      = 0;
    int m_retry   = 0;
    int m_loss    = 0;
    bit m_s1      = 1'b0;
    bit m_s2      = 1'b0;
    bit m_started = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_ph      = P_RST;
            m_el      = 0;
            m_retry   = 0;
            m_loss    = 0;
            m_s1      = 1'b0;
            m_s2      = 1'b0;
            m_started = 1'b1;
        end else begin
            m_el++;
            case (m_ph)
                P_RST: if (m_el == RC) begin m_ph = P_WAIT; m_el = 0; end
                P_WAIT: begin
                    if (m_s2) begin
                        m_ph = P_STB; m_el = 0;
                    end else if (m_el == TO) begin
                        m_retry++;
                        m_ph = (m_retry == MR) ? P_FLT : P_RST;
                        m_el = 0;
                    end
                end
                P_STB: begin
                    if (!m_s2) begin
                        m_ph = P_WAIT; m_el = 0;
                    end else if (m_el == SC) begin
                        m_ph = P_RUN; m_el = 0; m_retry = 0;
                    end
                end
                P_RUN: begin
                    if (!m_s2) begin
                        m_ph = P_RST; m_el = 0;
                        if (m_loss < 255) m_loss++;
                    end
                end
                default: begin
                    if (restart) begin m_ph = P_RST; m_el = 0; m_retry = 0; end
                end
            endcase
            m_s2 = m_s1;
            m_s1 = lock;
        end
    end

    always @(negedge clk) begin
        if (m_started) begin
            chk("m_pll_rst_n", 32'(pll_rst_n),
                32'((m_ph == P_WAIT) || (m_ph == P_STB) || (m_ph == P_RUN)));
            chk("m_ready", 32'(ready), 32'(m_ph == P_RUN));
            chk("m_tx_rst", 32'(tx_rst), 32'(m_ph != P_RUN));
            chk("m_fault", 32'(fault), 32'(m_ph == P_FLT));
            chk("m_retry_count", 32'(retry_count), 32'(m_retry));
            chk("m_loss_count", 32'(loss_count), 32'(m_loss));
        end
    end

    // ---------------- directed stimulus ----------------
    initial begin
        rst = 1'b1; lock = 1'b0; restart = 1'b0;
        step(2);
        chk("rst_pll_rst_n", 32'(pll_rst_n), 0);
        chk("rst_tx_rst", 32'(tx_rst), 1);
        chk("rst_ready", 32'(ready), 0);
        chk("rst_fault", 32'(fault), 0);
        rst = 1'b0;

        // 1: power-up lock
        step(3);
        chk("t1_prst_n_hold", 32'(pll_rst_n), 0);
        step(1);
        chk("t1_prst_n_rise", 32'(pll_rst_n), 1);
        step(5);
        lock = 1'b1;
        step(10);
        chk("t1_ready_early", 32'(ready), 0);
        step(1);
        chk("t1_ready", 32'(ready), 1);
        chk("t1_tx_rst", 32'(tx_rst), 0);
        chk("t1_retry", 32'(retry_count), 0);

        // 2: lock loss in RUN
        step(3);
        lock = 1'b0;
        step(2);
        chk("t2_ready_hold", 32'(ready), 1);
        step(1);
        chk("t2_ready_drop", 32'(ready), 0);
        chk("t2_tx_rst", 32'(tx_rst), 1);
        chk("t2_pll_rst_n", 32'(pll_rst_n), 0);
        chk("t2_loss", 32'(loss_count), 1);
        step(3);
        chk("t2_prst_low", 32'(pll_rst_n), 0);
        step(1);
        chk("t2_prst_rise", 32'(pll_rst_n), 1);
        step(4);
        lock = 1'b1;
        wait_ready("t2_relock");

        // 3: no lock -> retries -> fault -> restart
        step(2);
        lock = 1'b0;
        step(3);
        chk("t3_loss", 32'(loss_count), 2);
        step(4);
        chk("t3_wait1", 32'(pll_rst_n), 1);
        step(19);
        chk("t3_retry0", 32'(retry_count), 0);
        step(1);
        chk("t3_retry1", 32'(retry_count), 1);
        chk("t3_reset2", 32'(pll_rst_n), 0);
        step(4);
        chk("t3_wait2", 32'(pll_rst_n), 1);
        step(19);
        chk("t3_fault_early", 32'(fault), 0);
        step(1);
        chk("t3_fault", 32'(fault), 1);
        chk("t3_retry2", 32'(retry_count), 2);
        chk("t3_fault_prst", 32'(pll_rst_n), 0);
        step(30);
        chk("t3_fault_held", 32'(fault), 1);
        chk("t3_fault_prst_held", 32'(pll_rst_n), 0);
        restart = 1'b1;
        step(1);
        restart = 1'b0;
        chk("t3_restart_fault", 32'(fault), 0);
        chk("t3_restart_retry", 32'(retry_count), 0);
        step(3);
        chk("t3_restart_prst_low", 32'(pll_rst_n), 0);
        step(1);
        chk("t3_restart_prst_rise", 32'(pll_rst_n), 1);

        // 4: lock glitch inside STABLE
        lock = 1'b1;
        step(3);
        step(3);
        lock = 1'b0;
        step(3);
        lock = 1'b1;
        step(10);
        chk("t4_ready_early", 32'(ready), 0);
        chk("t4_retry", 32'(retry_count), 0);
        step(1);
        chk("t4_ready", 32'(ready), 1);

        // 5: restart ignored in RUN, then one-cycle rst
        restart = 1'b1;
        step(1);
        restart = 1'b0;
        chk("t5_restart_ignored", 32'(ready), 1);
        chk("t5_loss_kept", 32'(loss_count), 2);
        step(2);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("t5_prst", 32'(pll_rst_n), 0);
        chk("t5_tx_rst", 32'(tx_rst), 1);
        chk("t5_ready", 32'(ready), 0);
        chk("t5_fault", 32'(fault), 0);
        chk("t5_retry", 32'(retry_count), 0);
        chk("t5_loss", 32'(loss_count), 0);
        step(3);
        chk("t5_prst_low", 32'(pll_rst_n), 0);
        step(1);
        chk("t5_prst_rise", 32'(pll_rst_n), 1);

        // 6: loss counter saturation
        wait_ready("t6_first_ready");
        for (int i = 1; i <= 256; i++) begin
            lock = 1'b0;
            step(3);
            chk("t6_drop", 32'(ready), 0);
            lock = 1'b1;
            wait_ready("t6_relock");
            if (i == 254) chk("t6_loss_254", 32'(loss_count), 254);
        end
        chk("t6_loss_sat", 32'(loss_count), 255);

        step(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        failures++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
